// File: rtl/as_pack.sv
// as_pack: shared definitions for the JTAG debug port.
//   ir_width    - default instruction register width
//   tap_state_t - IEEE 1149.1 TAP state encoding
//   IDCODE, BYPASS, USER - instruction opcodes
//   IR_RESET    - value loaded into ir_reg in Test-Logic-Reset
package as_pack;

    localparam int ir_width = 8;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    localparam logic [ir_width-1:0] IDCODE   = 8'h01;
    localparam logic [ir_width-1:0] USER     = 8'h10;
    localparam logic [ir_width-1:0] BYPASS   = 8'hFF;
    localparam logic [ir_width-1:0] IR_RESET = IDCODE;

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state TAP state register and next-state logic.
//   tck   - JTAG clock, state advances on the rising edge
//   trst  - synchronous active-high reset into Test-Logic-Reset
//   tms   - mode select steering the transitions
//   state - current TAP state
module tap_fsm
    import as_pack::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t state_nxt;

    always_comb begin
        state_nxt = TLR;
        unique case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // trst wins over tms, so an in-flight scan is abandoned without
    // passing through an update state.
    always_ff @(posedge tck) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP controller.
//   tck, trst, tms        - JTAG clock, sync active-high reset, mode select
//   ir_q                  - current instruction from ir_reg
//   ir_sero, dr_sero      - serial outputs of ir_reg and the selected DR
//   ir_shift/clock/upd    - ir_reg shift select, clock enable, update enable
//   dr_shift/clock/upd    - the same enables for the data registers
//   tap_rst               - high in Test-Logic-Reset
//   sel_bypass/idcode/user- one-hot data-register select from ir_q
//   tdo, tdo_oe           - serial output and its enable
//   state                 - current TAP state for debug
module tap_ctrl
    import as_pack::*;
#(
    parameter int IR_W = ir_width
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tms,
    input  logic [IR_W-1:0] ir_q,
    input  logic            ir_sero,
    input  logic            dr_sero,
    output logic            ir_shift,
    output logic            ir_clock,
    output logic            ir_upd,
    output logic            dr_shift,
    output logic            dr_clock,
    output logic            dr_upd,
    output logic            tap_rst,
    output logic            sel_bypass,
    output logic            sel_idcode,
    output logic            sel_user,
    output logic            tdo,
    output logic            tdo_oe,
    output logic [3:0]      state
);

    tap_state_t cur;

    tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (cur)
    );

    assign state = cur;

    // Moore enables: each one is valid for the whole cycle in its state and
    // the target register acts on the edge that leaves that state.
    always_comb begin
        ir_shift = 1'b0;
        ir_clock = 1'b0;
        ir_upd   = 1'b0;
        dr_shift = 1'b0;
        dr_clock = 1'b0;
        dr_upd   = 1'b0;
        tap_rst  = 1'b0;
        tdo      = 1'b0;
        tdo_oe   = 1'b0;
        case (cur)
            TLR:    tap_rst  = 1'b1;
            CAP_IR: ir_clock = 1'b1;
            SH_IR: begin
                ir_clock = 1'b1;
                ir_shift = 1'b1;
                tdo      = ir_sero;
                tdo_oe   = 1'b1;
            end
            UPD_IR: ir_upd   = 1'b1;
            CAP_DR: dr_clock = 1'b1;
            SH_DR: begin
                dr_clock = 1'b1;
                dr_shift = 1'b1;
                tdo      = dr_sero;
                tdo_oe   = 1'b1;
            end
            UPD_DR: dr_upd   = 1'b1;
            default: ;
        endcase
    end

    // Unknown opcodes fall back to BYPASS so exactly one select is always high.
    always_comb begin
        sel_idcode = 1'b0;
        sel_user   = 1'b0;
        sel_bypass = 1'b0;
        if (ir_q == IR_W'(IDCODE)) begin
            sel_idcode = 1'b1;
        end else if (ir_q == IR_W'(USER)) begin
            sel_user = 1'b1;
        end else begin
            sel_bypass = 1'b1;
        end
    end

endmodule

// File: tb/tb_tap_ctrl.sv
module tb_tap_ctrl;
    import as_pack::*;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic [7:0] ir_q;
    logic [7:0] ir_sr;
    logic       ir_sero;
    logic       dr_sero = 1'b0;
    logic       ir_shift, ir_clock, ir_upd;
    logic       dr_shift, dr_clock, dr_upd;
    logic       tap_rst, sel_bypass, sel_idcode, sel_user, tdo, tdo_oe;
    logic [3:0] state;

    int total = 0;
    int bad = 0;

    tap_ctrl #(.IR_W(8)) dut (
        .tck(tck), .trst(trst), .tms(tms), .ir_q(ir_q), .ir_sero(ir_sero),
        .dr_sero(dr_sero), .ir_shift(ir_shift), .ir_clock(ir_clock),
        .ir_upd(ir_upd), .dr_shift(dr_shift), .dr_clock(dr_clock),
        .dr_upd(dr_upd), .tap_rst(tap_rst), .sel_bypass(sel_bypass),
        .sel_idcode(sel_idcode), .sel_user(sel_user), .tdo(tdo),
        .tdo_oe(tdo_oe), .state(state)
    );

    always #5 tck = ~tck;

    // Connected ir_reg: captures 8'h01, shifts LSB first from tdi.
    assign ir_sero = ir_sr[0];
    always @(posedge tck) begin
        if (tap_rst) begin
            ir_q  <= IR_RESET;
            ir_sr <= 8'h00;
        end else begin
            if (ir_clock) ir_sr <= ir_shift ? {tdi, ir_sr[7:1]} : 8'h01;
            if (ir_upd)   ir_q  <= ir_sr;
        end
    end

    // Reference model: transition table straight from the state list.
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] mstate;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against what the model state implies.
    task automatic check_model();
        logic is_shir, is_shdr;
        logic [7:0] en_exp, en_act, sel_exp, sel_act;
        is_shir = (mstate == 4'hA);
        is_shdr = (mstate == 4'h2);
        en_exp = {mstate == 4'hE || is_shir, is_shir, mstate == 4'hD,
                  mstate == 4'h6 || is_shdr, is_shdr, mstate == 4'h5,
                  mstate == 4'hF, is_shir || is_shdr};
        en_act = {ir_clock, ir_shift, ir_upd, dr_clock, dr_shift, dr_upd, tap_rst, tdo_oe};
        sel_exp = {5'd0, ir_q == 8'h01, ir_q == 8'h10, !(ir_q == 8'h01 || ir_q == 8'h10)};
        sel_act = {5'd0, sel_idcode, sel_user, sel_bypass};
        chk("state", {4'h0, state}, {4'h0, mstate});
        chk("enables", en_act, en_exp);
        chk("selects", sel_act, sel_exp);
        chk("tdo", {7'd0, tdo}, {7'd0, is_shir ? ir_sero : (is_shdr ? dr_sero : 1'b0)});
    endtask

    task automatic step(input logic t_rst, input logic t_ms, input logic t_di);
        @(negedge tck);
        trst    = t_rst;
        tms     = t_ms;
        tdi     = t_di;
        dr_sero = 1'($urandom_range(0, 1));
        @(posedge tck);
        mstate = t_rst ? 4'hF : (t_ms ? nxt1[mstate] : nxt0[mstate]);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       trst;
        logic       tms;
        logic [3:0] exp_state;
    } vec_t;

    vec_t vecs [7];
    int   upd_seen;
    logic [7:0] pattern;

    initial begin
        nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
        nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
        nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
        nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
        nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
        nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
        nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
        nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
        nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
        nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
        nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
        nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
        nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
        nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
        nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
        nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
        mstate = 4'hF;

        // Reset for two cycles, then the walk 0,1,1,0,0 to SH_IR.
        vecs[0] = '{1'b1, 1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b0, 4'hF};
        vecs[2] = '{1'b0, 1'b0, 4'hC};
        vecs[3] = '{1'b0, 1'b1, 4'h7};
        vecs[4] = '{1'b0, 1'b1, 4'h4};
        vecs[5] = '{1'b0, 1'b0, 4'hE};
        vecs[6] = '{1'b0, 1'b0, 4'hA};
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].trst, vecs[i].tms, 1'b0);
            chk($sformatf("vec%0d_state", i), {4'h0, state}, {4'h0, vecs[i].exp_state});
        end
        chk("reset_idcode", {7'd0, sel_idcode}, 8'h01);

        // IR scan of 8'h69 LSB first: 7 bits with tms=0, last bit with tms=1.
        pattern = 8'h69;
        for (int b = 0; b < 8; b++) step(1'b0, b == 7, pattern[b]);
        chk("ex1_ir", {4'h0, state}, 8'h09);
        step(1'b0, 1'b1, 1'b0);
        chk("upd_ir", {7'd0, ir_upd}, 8'h01);
        step(1'b0, 1'b0, 1'b0);
        chk("upd_pulse_end", {7'd0, ir_upd}, 8'h00);
        chk("ir_q_scanned", ir_q, 8'h69);
        chk("sel_bypass_69", {7'd0, sel_bypass}, 8'h01);

        // DR pause: RTI -> SH_DR, pause three cycles, resume shifting.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("sh_dr", {4'h0, state}, 8'h02);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("pau_dr_clock", {3'd0, dr_clock, 3'd0, state == 4'h3}, 8'h01);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_oe", {6'd0, tdo_oe, state == 4'h2}, 8'h03);
        chk("resume_tdo", {7'd0, tdo}, {7'd0, dr_sero});

        // Reach PAU_IR, then five tms=1 samples must land in TLR.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pau_ir", {4'h0, state}, 8'h0B);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
        chk("tms_reset", {4'h0, state}, 8'h0F);

        // trst during SH_IR aborts without any update strobe.
        upd_seen = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("pre_trst_shir", {4'h0, state}, 8'h0A);
        step(1'b1, 1'b0, 1'b0);
        if (ir_upd) upd_seen++;
        chk("trst_abort", {3'd0, tdo_oe, state}, 8'h0F);
        step(1'b1, 1'b1, 1'b0);
        if (ir_upd) upd_seen++;
        chk("trst_hold", {4'h0, state}, 8'h0F);
        step(1'b0, 1'b0, 1'b0);
        if (ir_upd) upd_seen++;
        chk("trst_no_upd", upd_seen[7:0], 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
